priority_interrupt_controller: RTL and testbench

//  Next-generation CPU interrupt controller: NUM_IRQ sources, each with its own edge/level type and polarity.

---
 rtl/pic_pkg.sv | 25 ++
 rtl/pic_if.sv | 22 ++
 rtl/pic_prio_enc.sv | 23 ++
 rtl/priority_interrupt_controller.sv | 177 +++++++++++++++++
 tb/tb_priority_interrupt_controller.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pic_pkg.sv
// Shared register map, claim word layout and helpers for the priority interrupt controller.
package pic_pkg;

  localparam logic [31:0] PIC_ENABLE  = 32'd0;
  localparam logic [31:0] PIC_PENDING = 32'd1;
  localparam logic [31:0] PIC_CLEAR   = 32'd2;
  localparam logic [31:0] PIC_TYPE    = 32'd3;
  localparam logic [31:0] PIC_POL     = 32'd4;
  localparam logic [31:0] PIC_CLAIM   = 32'd5;
  localparam logic [31:0] PIC_RAW     = 32'd6;

  // CLAIM valid flag sits this many bits below the data MSB.
  localparam int PIC_CLAIM_VALID_FROM_MSB = 0;
  localparam int PIC_MAX_ID_W             = 8;

  typedef struct packed {
    logic                    valid;
    logic [PIC_MAX_ID_W-1:0] id;
  } pic_claim_t;

  function automatic int pic_id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pic_if.sv
// CPU register bus between the processor (master) and the interrupt controller (slave).
interface pic_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  cpu_read;
  logic                  cpu_write;
  logic [ADDR_WIDTH-1:0] cpu_address;
  logic [DATA_WIDTH-1:0] cpu_write_data;
  logic [DATA_WIDTH-1:0] cpu_read_data;
  logic                  cpu_access_complete;

  modport master (
    output cpu_read, cpu_write, cpu_address, cpu_write_data,
    input  cpu_read_data, cpu_access_complete
  );

  modport slave (
    input  cpu_read, cpu_write, cpu_address, cpu_write_data,
    output cpu_read_data, cpu_access_complete
  );
endinterface

// File: rtl/pic_prio_enc.sv
// Find-first-set over N request bits: lowest set index wins.
module pic_prio_enc #(
  parameter int N    = 16,
  parameter int ID_W = 4
) (
  input  logic [N-1:0]    req,
  output logic            found,
  output logic [ID_W-1:0] id
);

  always_comb begin
    found = 1'b0;
    id    = '0;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        id    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/priority_interrupt_controller.sv
// Fixed-priority interrupt controller with claim/complete handshake.
// Define PIC_INPUT_SYNC_EN to insert a 2-flop synchronizer ahead of the input register.
module priority_interrupt_controller
  import pic_pkg::*;
#(
  parameter  int NUM_IRQ    = 16,
  parameter  int ADDR_WIDTH = 5,
  parameter  int DATA_WIDTH = 32,
  localparam int ID_W       = pic_id_width(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] ext_intr,
  pic_if.slave               bus,
  output logic               cpu_irq,
  output logic [ID_W-1:0]    cpu_irq_id
);

  localparam int VALID_BIT = DATA_WIDTH - 1 - PIC_CLAIM_VALID_FROM_MSB;

  logic [NUM_IRQ-1:0]    in_q, in_d, x, x_prev_q, edge_det;
  logic [NUM_IRQ-1:0]    enable_q, enable_d, type_q, type_d, pol_q, pol_d;
  logic [NUM_IRQ-1:0]    pending_q, pending_d, inj_q, inj_d;
  logic [NUM_IRQ-1:0]    w1s, w1c, claim_clr, busy_mask, cand;
  logic                  in_service_q, in_service_d;
  logic [ID_W-1:0]       svc_id_q, svc_id_d;
  logic                  cpu_irq_q, cpu_irq_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, rd_mux, claim_word;
  logic                  ack_q, ack_d;
  logic                  enc_found, claim_fire, complete_hit;
  logic [ID_W-1:0]       enc_id;
  logic [31:0]           word;
  pic_claim_t            claim;
  logic                  unused_bits;

`ifdef PIC_INPUT_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= ext_intr;
      sync2_q <= sync1_q;
    end
  end

  assign in_d = sync2_q;
`else
  assign in_d = ext_intr;
`endif

  // Conditioned input: high means "asserted" regardless of polarity.
  assign x        = in_q ^ ~pol_q;
  assign edge_det = x & ~x_prev_q;
  assign word     = 32'(bus.cpu_address[ADDR_WIDTH-1:2]);
  assign cand     = pending_q & enable_q & ~busy_mask;

  pic_prio_enc #(
    .N    (NUM_IRQ),
    .ID_W (ID_W)
  ) u_prio_enc (
    .req   (cand),
    .found (enc_found),
    .id    (enc_id)
  );

  always_comb begin
    enable_d = enable_q;
    type_d   = type_q;
    pol_d    = pol_q;
    w1s      = '0;
    w1c      = '0;
    if (bus.cpu_write) begin
      case (word)
        PIC_ENABLE:  enable_d = bus.cpu_write_data[NUM_IRQ-1:0];
        PIC_PENDING: w1s      = bus.cpu_write_data[NUM_IRQ-1:0];
        PIC_CLEAR:   w1c      = bus.cpu_write_data[NUM_IRQ-1:0];
        PIC_TYPE:    type_d   = bus.cpu_write_data[NUM_IRQ-1:0];
        PIC_POL:     pol_d    = bus.cpu_write_data[NUM_IRQ-1:0];
        default:     ;
      endcase
    end
  end

  always_comb begin
    claim.valid = enc_found & ~in_service_q;
    claim.id    = PIC_MAX_ID_W'(enc_id);
    claim_word  = '0;
    if (claim.valid) begin
      claim_word[VALID_BIT]  = 1'b1;
      claim_word[ID_W-1:0]   = claim.id[ID_W-1:0];
    end

    claim_fire   = bus.cpu_read && (word == PIC_CLAIM) && claim.valid;
    complete_hit = bus.cpu_write && (word == PIC_CLAIM) && in_service_q &&
                   (bus.cpu_write_data[ID_W-1:0] == svc_id_q);
    claim_clr    = claim_fire ? (NUM_IRQ'(1) << enc_id) : '0;

    in_service_d = in_service_q;
    svc_id_d     = svc_id_q;
    if (complete_hit) begin
      in_service_d = 1'b0;
    end
    if (claim_fire) begin
      in_service_d = 1'b1;
      svc_id_d     = enc_id;
    end

    // Raised only while idle; a claim in this cycle drops it on the next edge.
    cpu_irq_d = (|cand) && !in_service_q && !claim_fire;
  end

  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_src
    logic set_e, clr_e;
    assign set_e          = edge_det[gi] | w1s[gi];
    assign clr_e          = w1c[gi] | claim_clr[gi];
    assign inj_d[gi]      = ~type_q[gi] & ((inj_q[gi] & ~w1c[gi]) | w1s[gi]);
    assign pending_d[gi]  = type_q[gi] ? ((pending_q[gi] & ~clr_e) | set_e)
                                       : (x[gi] | inj_d[gi]);
    assign busy_mask[gi]  = in_service_q && (svc_id_q == ID_W'(gi));
  end

  // Reads observe the state as it was before this cycle's updates.
  always_comb begin
    rd_mux = '0;
    case (word)
      PIC_ENABLE:  rd_mux = DATA_WIDTH'(enable_q);
      PIC_PENDING: rd_mux = DATA_WIDTH'(pending_q);
      PIC_TYPE:    rd_mux = DATA_WIDTH'(type_q);
      PIC_POL:     rd_mux = DATA_WIDTH'(pol_q);
      PIC_CLAIM:   rd_mux = claim_word;
      PIC_RAW:     rd_mux = DATA_WIDTH'(x);
      default:     rd_mux = '0;
    endcase
    rdata_d = bus.cpu_read ? rd_mux : '0;
    ack_d   = bus.cpu_read | bus.cpu_write;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_q         <= '0;
      x_prev_q     <= '0;
      enable_q     <= '0;
      type_q       <= '0;
      pol_q        <= '1;
      pending_q    <= '0;
      inj_q        <= '0;
      in_service_q <= 1'b0;
      svc_id_q     <= '0;
      cpu_irq_q    <= 1'b0;
      rdata_q      <= '0;
      ack_q        <= 1'b0;
    end else begin
      in_q         <= in_d;
      x_prev_q     <= x;
      enable_q     <= enable_d;
      type_q       <= type_d;
      pol_q        <= pol_d;
      pending_q    <= pending_d;
      inj_q        <= inj_d;
      in_service_q <= in_service_d;
      svc_id_q     <= svc_id_d;
      cpu_irq_q    <= cpu_irq_d;
      rdata_q      <= rdata_d;
      ack_q        <= ack_d;
    end
  end

  assign cpu_irq                 = cpu_irq_q;
  assign cpu_irq_id              = enc_id;
  assign bus.cpu_read_data       = rdata_q;
  assign bus.cpu_access_complete = ack_q;
  assign unused_bits             = ^{bus.cpu_write_data, bus.cpu_address[1:0], claim};

endmodule

// File: tb/tb_priority_interrupt_controller.sv
// Directed bench for priority_interrupt_controller: register-map vector table plus timing/reset sequences.
module tb_priority_interrupt_controller;
  import pic_pkg::*;

`ifdef PIC_INPUT_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  typedef enum logic [1:0] {OP_IDLE, OP_RD, OP_WR, OP_RW} op_e;

  typedef struct {
    op_e         op;
    logic [15:0] ext;
    logic [31:0] word;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        chk_irq;
    logic        exp_irq;
    logic [3:0]  exp_id;
  } vec_t;

  logic        clk;
  logic        reset_n;
  logic [15:0] ext_intr;
  logic        cpu_irq;
  logic [3:0]  cpu_irq_id;
  int          errors;
  int          checks;
  int          txn;
  vec_t        vt[$];

  pic_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

  priority_interrupt_controller #(
    .NUM_IRQ    (16),
    .ADDR_WIDTH (5),
    .DATA_WIDTH (32)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ext_intr   (ext_intr),
    .bus        (bus),
    .cpu_irq    (cpu_irq),
    .cpu_irq_id (cpu_irq_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(op_e op, logic [15:0] ext, logic [31:0] word, logic [31:0] wd,
                              logic [31:0] er, logic ci, logic ei, logic [3:0] eid);
    vec_t v;
    v.op = op; v.ext = ext; v.word = word; v.wdata = wd;
    v.exp_rd = er; v.chk_irq = ci; v.exp_irq = ei; v.exp_id = eid;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // One bus cycle starting and ending just after a falling edge.
  task automatic bus_cycle(input logic rd, input logic wr, input logic [31:0] word,
                           input logic [31:0] wd, output logic [31:0] rdata, output logic cpl);
    bus.cpu_read       = rd;
    bus.cpu_write      = wr;
    bus.cpu_address    = 5'(word << 2);
    bus.cpu_write_data = wd;
    @(negedge clk);
    bus.cpu_read  = 1'b0;
    bus.cpu_write = 1'b0;
    rdata = bus.cpu_read_data;
    cpl   = bus.cpu_access_complete;
    txn++;
    $display("txn %0d rd=%0b wr=%0b word=%0d wdata=%08h rdata=%08h ack=%0b irq=%0b id=%0d",
             txn, rd, wr, word, wd, rdata, cpl, cpu_irq, cpu_irq_id);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] word, input logic [31:0] exp);
    logic [31:0] d;
    logic        c;
    bus_cycle(1'b1, 1'b0, word, 32'h0, d, c);
    chk({name, "_ack"}, 32'(c), 32'd1);
    chk(name, d, exp);
  endtask

  task automatic wr_reg(input logic [31:0] word, input logic [31:0] wd);
    logic [31:0] d;
    logic        c;
    bus_cycle(1'b0, 1'b1, word, wd, d, c);
    chk("wr_ack", 32'(c), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] d;
    logic        c;
    ext_intr = v.ext;
    bus_cycle(v.op == OP_RD || v.op == OP_RW, v.op == OP_WR || v.op == OP_RW, v.word, v.wdata, d, c);
    chk($sformatf("v%0d_ack", idx), 32'(c), 32'(v.op != OP_IDLE));
    if (v.op == OP_RD || v.op == OP_RW) chk($sformatf("v%0d_rdata", idx), d, v.exp_rd);
    if (v.chk_irq) begin
      chk($sformatf("v%0d_irq", idx), 32'(cpu_irq), 32'(v.exp_irq));
      chk($sformatf("v%0d_id", idx), 32'(cpu_irq_id), 32'(v.exp_id));
    end
  endtask

  initial begin
    logic [31:0] d;
    logic        c;
    errors = 0; checks = 0; txn = 0;
    reset_n = 1'b0; ext_intr = '0;
    bus.cpu_read = 1'b0; bus.cpu_write = 1'b0; bus.cpu_address = '0; bus.cpu_write_data = '0;

    // Reset state and edge source 2
    vt.push_back(mk(OP_RD,   16'h0, PIC_ENABLE,  0, 32'h0, 1, 0, 0));
    vt.push_back(mk(OP_RD,   16'h0, PIC_POL,     0, 32'h0000_FFFF, 0, 0, 0));
    vt.push_back(mk(OP_RD,   16'h0, PIC_TYPE,    0, 32'h0, 0, 0, 0));
    vt.push_back(mk(OP_RD,   16'h0, PIC_PENDING, 0, 32'h0, 0, 0, 0));
    vt.push_back(mk(OP_RD,   16'h0, PIC_CLAIM,   0, 32'h0, 1, 0, 0));
    vt.push_back(mk(OP_WR,   16'h0, PIC_TYPE,    32'h4, 0, 0, 0, 0));
    vt.push_back(mk(OP_WR,   16'h0, PIC_ENABLE,  32'h4, 0, 0, 0, 0));
    vt.push_back(mk(OP_IDLE, 16'h4, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(OP_IDLE, 16'h0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(OP_IDLE, 16'h0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(OP_IDLE, 16'h0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(OP_IDLE, 16'h0, 0, 0, 0, 1, 1, 2));
    vt.push_back(mk(OP_RD,   16'h0, PIC_PENDING, 0, 32'h4, 1, 1, 2));
    vt.push_back(mk(OP_RD,   16'h0, PIC_CLAIM,   0, 32'h8000_0002, 1, 0, 0));
    vt.push_back(mk(OP_RD,   16'h0, PIC_PENDING, 0, 32'h0, 1, 0, 0));
    vt.push_back(mk(OP_WR,   16'h0, PIC_CLAIM,   32'h2, 0, 0, 0, 0));
    vt.push_back(mk(OP_IDLE, 16'h0, 0, 0, 0, 1, 0, 0));
    // Simultaneous edges on 5 and 3; wrong-id complete; no nesting
    vt.push_back(mk(OP_WR,   16'h0,  PIC_TYPE,   32'h28, 0, 0, 0, 0));
    vt.push_back(mk(OP_WR,   16'h0,  PIC_ENABLE, 32'h28, 0, 0, 0, 0));
    vt.push_back(mk(OP_IDLE, 16'h28, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(OP_IDLE, 16'h0,  0, 0, 0, 0, 0, 0));
    vt.push_back(mk(OP_IDLE, 16'h0,  0, 0, 0, 0, 0, 0));
    vt.push_back(mk(OP_IDLE, 16'h0,  0, 0, 0, 0, 0, 0));
    vt.push_back(mk(OP_IDLE, 16'h0,  0, 0, 0, 1, 1, 3));
    vt.push_back(mk(OP_RD,   16'h0,  PIC_CLAIM,  0, 32'h8000_0003, 1, 0, 5));
    vt.push_back(mk(OP_RD,   16'h0,  PIC_CLAIM,  0, 32'h0, 1, 0, 5));
    vt.push_back(mk(OP_WR,   16'h0,  PIC_CLAIM,  32'h7, 0, 0, 0, 0));
    vt.push_back(mk(OP_RD,   16'h0,  PIC_CLAIM,  0, 32'h0, 1, 0, 5));
    vt.push_back(mk(OP_WR,   16'h0,  PIC_CLAIM,  32'h3, 0, 0, 0, 0));
    vt.push_back(mk(OP_IDLE, 16'h0,  0, 0, 0, 1, 1, 5));
    vt.push_back(mk(OP_RD,   16'h0,  PIC_CLAIM,  0, 32'h8000_0005, 1, 0, 0));
    vt.push_back(mk(OP_WR,   16'h0,  PIC_CLAIM,  32'h5, 0, 0, 0, 0));
    vt.push_back(mk(OP_WR,   16'h0,  PIC_ENABLE, 32'h0, 0, 0, 0, 0));
    // Level source 0, active low
    vt.push_back(mk(OP_WR,   16'h0, PIC_POL,    32'hFFFE, 0, 0, 0, 0));
    vt.push_back(mk(OP_WR,   16'h0, PIC_ENABLE, 32'h1, 0, 0, 0, 0));
    vt.push_back(mk(OP_IDLE, 16'h0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(OP_IDLE, 16'h0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(OP_IDLE, 16'h0, 0, 0, 0, 1, 1, 0));
    vt.push_back(mk(OP_RD,   16'h0, PIC_RAW,    0, 32'h1, 1, 1, 0));
    vt.push_back(mk(OP_RD,   16'h0, PIC_CLAIM,  0, 32'h8000_0000, 1, 0, 0));
    vt.push_back(mk(OP_WR,   16'h0, PIC_CLAIM,  32'h0, 0, 0, 0, 0));
    vt.push_back(mk(OP_IDLE, 16'h0, 0, 0, 0, 1, 1, 0));
    vt.push_back(mk(OP_IDLE, 16'h1, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(OP_IDLE, 16'h1, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(OP_IDLE, 16'h1, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(OP_IDLE, 16'h1, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(OP_IDLE, 16'h1, 0, 0, 0, 1, 0, 0));
    vt.push_back(mk(OP_RD,   16'h1, PIC_PENDING, 0, 32'h0, 0, 0, 0));
    vt.push_back(mk(OP_WR,   16'h1, PIC_ENABLE, 32'h0, 0, 0, 0, 0));
    vt.push_back(mk(OP_WR,   16'h0, PIC_POL,    32'hFFFF, 0, 0, 0, 0));
    vt.push_back(mk(OP_IDLE, 16'h0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(OP_IDLE, 16'h0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(OP_IDLE, 16'h0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(OP_IDLE, 16'h0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(OP_RD,   16'h0, PIC_PENDING, 0, 32'h0, 0, 0, 0));
    // Injected level source 4 gated by ENABLE, removed by W1C
    vt.push_back(mk(OP_WR,   16'h0, PIC_PENDING, 32'h10, 0, 0, 0, 0));
    vt.push_back(mk(OP_IDLE, 16'h0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(OP_IDLE, 16'h0, 0, 0, 0, 1, 0, 0));
    vt.push_back(mk(OP_RD,   16'h0, PIC_PENDING, 0, 32'h10, 0, 0, 0));
    vt.push_back(mk(OP_WR,   16'h0, PIC_ENABLE,  32'h10, 0, 0, 0, 0));
    vt.push_back(mk(OP_IDLE, 16'h0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(OP_IDLE, 16'h0, 0, 0, 0, 1, 1, 4));
    vt.push_back(mk(OP_WR,   16'h0, PIC_CLEAR,   32'h10, 0, 0, 0, 0));
    vt.push_back(mk(OP_IDLE, 16'h0, 0, 0, 0, 1, 0, 0));
    vt.push_back(mk(OP_RD,   16'h0, PIC_PENDING, 0, 32'h0, 0, 0, 0));
    vt.push_back(mk(OP_WR,   16'h0, 32'd7, 32'hFFFF_FFFF, 0, 0, 0, 0));
    vt.push_back(mk(OP_RD,   16'h0, 32'd7, 0, 32'h0, 0, 0, 0));
    vt.push_back(mk(OP_RD,   16'h0, PIC_CLEAR,   0, 32'h0, 0, 0, 0));
    vt.push_back(mk(OP_RD,   16'h0, PIC_ENABLE,  0, 32'h10, 0, 0, 0));

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vt.size(); i++) run_vec(vt[i], i);

    // Exact edge-to-pending and pending-to-irq latency on source 1
    wr_reg(PIC_TYPE, 32'h2);
    wr_reg(PIC_ENABLE, 32'h2);
    repeat (2) @(negedge clk);
    ext_intr = 16'h2;
    @(negedge clk);
    ext_intr = 16'h0;
    chk("lat_early_id", 32'(cpu_irq_id), 32'd0);
    repeat (1 + SL) @(negedge clk);
    chk("lat_pend_id", 32'(cpu_irq_id), 32'd1);
    chk("lat_irq_lo", 32'(cpu_irq), 32'd0);
    @(negedge clk);
    chk("lat_irq_hi", 32'(cpu_irq), 32'd1);
    rd_chk("lat_claim", PIC_CLAIM, 32'h8000_0001);
    wr_reg(PIC_CLAIM, 32'h1);

    // Read and write in the same cycle: read returns the old value
    bus_cycle(1'b1, 1'b1, PIC_ENABLE, 32'h6, d, c);
    chk("rw_old", d, 32'h2);
    rd_chk("rw_new", PIC_ENABLE, 32'h6);

    // Edge arriving in the same cycle as W1C keeps the bit pending
    wr_reg(PIC_PENDING, 32'h2);
    ext_intr = 16'h2;
    @(negedge clk);
    ext_intr = 16'h0;
    repeat (SL) @(negedge clk);
    wr_reg(PIC_CLEAR, 32'h2);
    rd_chk("set_beats_clr", PIC_PENDING, 32'h2);
    wr_reg(PIC_CLEAR, 32'h2);
    rd_chk("w1c_edge", PIC_PENDING, 32'h0);

    // Asynchronous reset in the middle of a claim
    wr_reg(PIC_PENDING, 32'h2);
    rd_chk("pre_rst_claim", PIC_CLAIM, 32'h8000_0001);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_ack_async", 32'(bus.cpu_access_complete), 32'd0);
    chk("rst_rdata_async", bus.cpu_read_data, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    rd_chk("rst_enable", PIC_ENABLE, 32'h0);
    rd_chk("rst_type", PIC_TYPE, 32'h0);
    rd_chk("rst_pol", PIC_POL, 32'h0000_FFFF);
    rd_chk("rst_pending", PIC_PENDING, 32'h0);
    wr_reg(PIC_PENDING, 32'h10);
    wr_reg(PIC_ENABLE, 32'h10);
    repeat (2) @(negedge clk);
    chk("post_rst_irq", 32'(cpu_irq), 32'd1);
    chk("post_rst_id", 32'(cpu_irq_id), 32'd4);

    // Reset with cpu_irq high drops it without waiting for a clock
    #2 reset_n = 1'b0;
    #1;
    chk("rst_irq_async", 32'(cpu_irq), 32'd0);
    chk("rst_id_async", 32'(cpu_irq_id), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
